pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen_if.sv | 34 +++
 rtl/pattern_gen.sv | 141 ++++++++++++++
 tb/tb_pattern_gen.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_if.sv
// Control/status bundle for pattern_gen: load/start requests in, serial stream and status out.
interface pattern_gen_if #(
    parameter int unsigned PAT_BITS = 4
);
    logic                load;
    logic [PAT_BITS-1:0] pattern;
    logic [3:0]          repeat_cnt;
    logic                start;
    logic                o;
    logic                busy;
    logic                done;

    // Requester side: presents patterns and start requests, observes the stream.
    modport master (
        output load,
        output pattern,
        output repeat_cnt,
        output start,
        input  o,
        input  busy,
        input  done
    );

    // Generator side: consumes requests, drives the serial stream and status.
    modport slave (
        input  load,
        input  pattern,
        input  repeat_cnt,
        input  start,
        output o,
        output busy,
        output done
    );
endinterface

// File: rtl/pattern_gen.sv
// Serial pattern generator: shifts a stored pattern out MSB first, repeat_cnt+1 times
// back to back, then pulses done for one cycle. All outputs are registered.
// Optional feature: define PATTERN_GEN_PARITY_EN to append an even-parity bit after
// every pattern repetition.
module pattern_gen #(
    parameter int unsigned PAT_BITS   = 4,
    parameter logic        IDLE_VALUE = 1'b1
) (
    input  logic           clk,
    input  logic           n_rst,
    pattern_gen_if.slave   bus
);
    localparam int unsigned IDX_W = (PAT_BITS > 1) ? $clog2(PAT_BITS) : 1;
    localparam int unsigned REP_W = 4;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_BITS - 1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_BITS-1:0] pat_reg_q, pat_reg_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                o_q, o_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PAT_BITS-1:0] tx_pat_c;
    logic                end_pat_c;

    // A load presented together with start is transmitted directly (bypass).
    assign tx_pat_c = bus.load ? bus.pattern : pat_reg_q;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            pat_reg_q <= '0;
            bit_idx_q <= '0;
            rep_q     <= '0;
            o_q       <= IDLE_VALUE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_reg_q <= pat_reg_d;
            bit_idx_q <= bit_idx_d;
            rep_q     <= rep_d;
            o_q       <= o_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        pat_reg_d = pat_reg_q;
        bit_idx_d = bit_idx_q;
        rep_d     = rep_q;
        o_d       = o_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        end_pat_c = 1'b0;

        case (state_q)
            IDLE: begin
                o_d    = IDLE_VALUE;
                busy_d = 1'b0;
                if (bus.load) begin
                    pat_reg_d = bus.pattern;
                end
                if (bus.start) begin
                    state_d   = SHIFT;
                    o_d       = tx_pat_c[PAT_BITS-1];
                    bit_idx_d = IDX_MAX;
                    rep_d     = bus.repeat_cnt;
                    busy_d    = 1'b1;
                end
            end

            SHIFT: begin
                if (bit_idx_q != '0) begin
                    o_d       = pat_reg_q[bit_idx_q - IDX_ONE];
                    bit_idx_d = bit_idx_q - IDX_ONE;
                end else begin
`ifdef PATTERN_GEN_PARITY_EN
                    state_d = PARITY;
                    o_d     = ^pat_reg_q;
`else
                    end_pat_c = 1'b1;
`endif
                end
            end

            PARITY: begin
                end_pat_c = 1'b1;
            end

            DONE: begin
                // start/load here are deliberately dropped; one idle cycle follows.
                state_d = IDLE;
                o_d     = IDLE_VALUE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                o_d     = IDLE_VALUE;
                busy_d  = 1'b0;
            end
        endcase

        // End of one pattern: either restart with zero gap or finish.
        if (end_pat_c) begin
            if (rep_q != '0) begin
                state_d   = SHIFT;
                rep_d     = rep_q - REP_ONE;
                o_d       = pat_reg_q[PAT_BITS-1];
                bit_idx_d = IDX_MAX;
            end else begin
                state_d = DONE;
                o_d     = IDLE_VALUE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    assign bus.o    = o_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: each started transmission pushes its expected
// per-cycle (o, busy, done) tuples; tuples are popped and compared as cycles elapse.
module tb_pattern_gen;
    localparam int unsigned PB = 4;
`ifdef PATTERN_GEN_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    typedef struct packed {
        logic o;
        logic busy;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pattern_gen_if #(.PAT_BITS(PB)) bus ();

    pattern_gen #(
        .PAT_BITS  (PB),
        .IDLE_VALUE(1'b1)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    // Expected stream for one start: (reps+1) patterns MSB first, optional parity, done pulse.
    function automatic void push_tx(input logic [PB-1:0] pat, input int reps);
        exp_t e;
        for (int r = 0; r <= reps; r++) begin
            for (int i = int'(PB) - 1; i >= 0; i--) begin
                e = '{o: pat[i], busy: 1'b1, done: 1'b0};
                sb_q.push_back(e);
            end
            if (PAR_BITS != 0) begin
                e = '{o: ^pat, busy: 1'b1, done: 1'b0};
                sb_q.push_back(e);
            end
        end
        e = '{o: 1'b1, busy: 1'b0, done: 1'b1};
        sb_q.push_back(e);
    endfunction

    function automatic void push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{o: 1'b1, busy: 1'b0, done: 1'b0};
            sb_q.push_back(e);
        end
    endfunction

    task automatic drive(input logic ld, input logic [PB-1:0] pat, input logic [3:0] rc,
                         input logic st);
        bus.load       = ld;
        bus.pattern    = pat;
        bus.repeat_cnt = rc;
        bus.start      = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        n_rst = 1'b0;
        drive(1'b0, '0, 4'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL reset cyc%0d: o/busy/done=%b want 100", i, got);
            end
        end
        n_rst = 1'b1;
    endtask

    task automatic test_single();
        exp_t       e;
        logic [2:0] got;
        int         cyc;
        drive(1'b1, 4'b1101, 4'd0, 1'b0);
        tick();
        got = {bus.o, bus.busy, bus.done};
        checks++;
        if (got !== 3'b100) begin
            errors++;
            $display("FAIL load_only: o/busy/done=%b want 100", got);
        end
        // Start from stored pattern while a different value sits on the bus.
        drive(1'b0, 4'b0010, 4'd0, 1'b1);
        push_tx(4'b1101, 0);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_repeat();
        exp_t       e;
        logic [2:0] got;
        logic [3:0] sh;
        int         hits;
        int         cyc;
        sh   = '0;
        hits = 0;
        drive(1'b1, 4'b1101, 4'd1, 1'b1);
        push_tx(4'b1101, 1);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            if (bus.busy === 1'b1) begin
                sh = {sh[2:0], bus.o};
                if (sh == 4'b1101) hits++;
            end
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL repeat cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("FAIL detect_1101: hits=%0d want 2", hits);
        end
    endtask

    task automatic test_ignore_busy();
        exp_t       e;
        logic [2:0] got;
        int         cyc;
        drive(1'b1, 4'b1100, 4'd0, 1'b1);
        push_tx(4'b1100, 0);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            if (cyc == 1) drive(1'b1, 4'b0011, 4'd3, 1'b1);
            if (cyc == 2) drive(1'b0, '0, 4'd0, 1'b0);
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ignore cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
        // Stored pattern must still be the original one.
        drive(1'b0, 4'b0011, 4'd0, 1'b1);
        push_tx(4'b1100, 0);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL keep_pat cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [2:0] got;
        logic [3:0] pat;
        int         cyc;
        pat = 4'b1011;
        drive(1'b1, pat, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) drive(1'b0, '0, 4'd0, 1'b0);
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== {pat[3-i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL pre_abort cyc%0d: o/busy/done=%b want %b", i + 1, got,
                         {pat[3-i], 1'b1, 1'b0});
            end
        end
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL abort cyc%0d: o/busy/done=%b want 100", i, got);
            end
            tick();
        end
        // Reset cleared the stored pattern: start without load sends zeros.
        drive(1'b0, 4'b1111, 4'd0, 1'b1);
        push_tx(4'b0000, 0);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cleared_pat cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
        drive(1'b1, pat, 4'd0, 1'b1);
        push_tx(pat, 0);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL post_abort cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_max_repeat();
        exp_t       e;
        logic [2:0] got;
        int         cyc;
        drive(1'b1, 4'b1000, 4'd15, 1'b1);
        push_tx(4'b1000, 15);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) drive(1'b0, '0, 4'd0, 1'b0);
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL max_rep cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [2:0] got;
        int         cyc;
        int         drop_at;
        // start held high: ignored in DONE, taken on the following idle cycle.
        drop_at = int'(PB + PAR_BITS) + 2;
        drive(1'b1, 4'b0110, 4'd0, 1'b1);
        push_tx(4'b0110, 0);
        push_idle(1);
        push_tx(4'b0110, 0);
        push_idle(1);
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick();
            if (cyc == 0) bus.load = 1'b0;
            if (cyc == drop_at) bus.start = 1'b0;
            e   = sb_q.pop_front();
            got = {bus.o, bus.busy, bus.done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b cyc%0d: o/busy/done=%b want %b", cyc + 1, got, e);
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_ignore_busy();
        test_reset_mid();
        test_max_repeat();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
